// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load funct3 encodings, datapath widths and the
// writeback queue entry / source-select types.
package cpu_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int WB_FIFO_DEPTH = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              x0;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment and sign/zero extension.
// Unrecognised funct3 codes fall through to a full-word load.
module load_extend
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  w_lanes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lanes[gi] = data[gi*8 +: 8];
        end
    endgenerate

    assign w_byte = w_lanes[off];
    assign w_half = off[1] ? data[31:16] : data[15:0];

    always_comb begin
        ext = data;
        case (funct3)
            F3_LB:   ext = {{24{w_byte[7]}}, w_byte};
            F3_LH:   ext = {{16{w_half[15]}}, w_half};
            F3_LW:   ext = data;
            F3_LBU:  ext = {24'd0, w_byte};
            F3_LHU:  ext = {16'd0, w_half};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: ALU results (no backpressure) win over a
// 2-entry queue of extended load responses; writes are registered.
module rf_writeback
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_byte_off,
    output logic              stall_req,
    output logic [REG_AW-1:0] rd_addr,
    output logic              rf_wr_en,
    output logic [XLEN-1:0]   wr_data
);

    wb_entry_t         r_fifo [WB_FIFO_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_stall_req;
    logic              r_rf_wr_en;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_wr_data;

    logic [XLEN-1:0]   w_ld_ext;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_nonempty;
    logic [1:0]        w_count_next;
    wb_src_e           w_sel;
    wb_entry_t         w_head;
    wb_entry_t         w_sel_entry;

    load_extend u_load_extend (
        .data   (ld_data),
        .funct3 (ld_funct3),
        .off    (ld_byte_off),
        .ext    (w_ld_ext)
    );

    assign ld_ready        = (r_count < 2'd2);
    assign w_push          = ld_valid && ld_ready;
    assign w_fifo_nonempty = (r_count != 2'd0);
    assign w_head          = r_fifo[r_rd_ptr];

    // While stalled the queue drains unconditionally, so upstream is
    // guaranteed to regain the port within two cycles.
    always_comb begin
        w_sel = SRC_NONE;
        if (r_stall_req && w_fifo_nonempty) begin
            w_sel = SRC_FIFO;
        end else if (alu_valid) begin
            w_sel = SRC_ALU;
        end else if (w_fifo_nonempty) begin
            w_sel = SRC_FIFO;
        end
    end

    assign w_pop = (w_sel == SRC_FIFO);

    always_comb begin
        w_sel_entry = w_head;
        if (w_sel == SRC_ALU) begin
            w_sel_entry.rd   = alu_rd;
            w_sel_entry.data = alu_data;
            w_sel_entry.x0   = (alu_rd == '0);
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Queue storage needs no reset: validity is carried by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{rd: ld_rd, data: w_ld_ext, x0: (ld_rd == '0)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_stall_req <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count     <= w_count_next;
            r_stall_req <= (r_count == 2'd2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_wr_en <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_rf_wr_en <= (w_sel != SRC_NONE) && !w_sel_entry.x0;
            if (w_sel != SRC_NONE) begin
                r_rd_addr <= w_sel_entry.rd;
                r_wr_data <= w_sel_entry.data;
            end
        end
    end

    assign stall_req = r_stall_req;
    assign rf_wr_en  = r_rf_wr_en;
    assign rd_addr   = r_rd_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: expected writes are queued at issue
// time and a negedge monitor compares every register-file write against them.
`timescale 1ns/1ps
module tb_rf_writeback;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_byte_off = '0;
    logic        stall_req;
    logic [4:0]  rd_addr;
    logic        rf_wr_en;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    rf_writeback dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_funct3   (ld_funct3),
        .ld_byte_off (ld_byte_off),
        .stall_req   (stall_req),
        .rd_addr     (rd_addr),
        .rf_wr_en    (rf_wr_en),
        .wr_data     (wr_data)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] data;
        logic [31:0] exp;
    } ld_vec_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    ld_vec_t ld_tab [8] = '{
        '{3'b001, 2'd2, 32'h80FF7F00, 32'hFFFF80FF},
        '{3'b001, 2'd0, 32'h12348765, 32'hFFFF8765},
        '{3'b101, 2'd2, 32'h87651234, 32'h00008765},
        '{3'b010, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF},
        '{3'b111, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D},
        '{3'b000, 2'd1, 32'h00007F00, 32'h0000007F},
        '{3'b100, 2'd0, 32'h000000FF, 32'h000000FF},
        '{3'b000, 2'd2, 32'h00AB0000, 32'hFFFFFFAB}
    };

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd_i, input logic [31:0] d_i);
        alu_valid = 1'b1;
        alu_rd    = rd_i;
        alu_data  = d_i;
        if (rd_i != 5'd0) exp_q.push_back(exp_t'{rd: rd_i, data: d_i});
    endtask

    task automatic drive_ld(input logic [4:0] rd_i, input logic [2:0] f3_i,
                            input logic [1:0] off_i, input logic [31:0] d_i);
        ld_valid    = 1'b1;
        ld_rd       = rd_i;
        ld_funct3   = f3_i;
        ld_byte_off = off_i;
        ld_data     = d_i;
    endtask

    // Scoreboard monitor: one line per observed write.
    always @(negedge clk) begin
        if (reset_n && rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write rd=%0d data=0x%08h", rd_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("WB rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                         rd_addr, wr_data, mon_e.rd, mon_e.data);
                chk("wb_rd", 32'(rd_addr), 32'(mon_e.rd));
                chk("wb_data", wr_data, mon_e.data);
            end
        end
    end

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        reset_n = 1'b1;

        // Plain ALU write, then idle hold
        drive_alu(5'd5, 32'h00001234);
        tick();
        chk("alu_wr_en", 32'(rf_wr_en), 32'd1);
        chk("alu_rd_addr", 32'(rd_addr), 32'd5);
        chk("alu_wr_data", wr_data, 32'h00001234);
        idle_inputs();
        tick();
        chk("idle_wr_en", 32'(rf_wr_en), 32'd0);
        chk("idle_rd_hold", 32'(rd_addr), 32'd5);
        chk("idle_data_hold", wr_data, 32'h00001234);

        // x0 destinations from both sources are consumed silently
        drive_alu(5'd0, 32'h0000FFFF);
        drive_ld(5'd0, 3'b010, 2'd0, 32'h00000055);
        tick();
        chk("x0_alu_wr_en", 32'(rf_wr_en), 32'd0);
        idle_inputs();
        tick();
        chk("x0_ld_wr_en", 32'(rf_wr_en), 32'd0);
        tick();
        chk("x0_drain_wr_en", 32'(rf_wr_en), 32'd0);
        chk("x0_ld_ready", 32'(ld_ready), 32'd1);

        // ALU busy while two loads fill the queue, then stall-driven drain
        drive_alu(5'd10, 32'hA0A0A0A0);
        drive_ld(5'd11, 3'b000, 2'd3, 32'h80FF7F00);
        tick();
        chk("fill1_ld_ready", 32'(ld_ready), 32'd1);
        drive_alu(5'd12, 32'hA1A1A1A1);
        drive_ld(5'd13, 3'b100, 2'd3, 32'h80FF7F00);
        tick();
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        drive_alu(5'd14, 32'hA2A2A2A2);
        drive_ld(5'd20, 3'b010, 2'd0, 32'hBADBADBA);
        tick();
        chk("stall_set", 32'(stall_req), 32'd1);
        chk("stall_ld_ready", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        exp_q.push_back(exp_t'{rd: 5'd11, data: 32'hFFFFFF80});
        exp_q.push_back(exp_t'{rd: 5'd13, data: 32'h00000080});
        tick();
        idle_inputs();
        chk("drain1_wr_en", 32'(rf_wr_en), 32'd1);
        chk("drain1_stall", 32'(stall_req), 32'd1);
        tick();
        chk("drain2_wr_en", 32'(rf_wr_en), 32'd1);
        chk("drain_stall_clr", 32'(stall_req), 32'd0);
        chk("drain_ld_ready", 32'(ld_ready), 32'd1);
        tick();

        // Back-to-back loads with the ALU idle: push and pop share cycles
        for (int i = 0; i < 8; i++) begin
            drive_ld(5'(i + 1), ld_tab[i].f3, ld_tab[i].off, ld_tab[i].data);
            exp_q.push_back(exp_t'{rd: 5'(i + 1), data: ld_tab[i].exp});
            tick();
            chk("b2b_ld_ready", 32'(ld_ready), 32'd1);
            if (i == 0) chk("ld_latency", 32'(rf_wr_en), 32'd0);
        end
        idle_inputs();
        repeat (3) tick();

        // Reset with a full queue discards both loads
        drive_alu(5'd23, 32'h23232323);
        drive_ld(5'd21, 3'b010, 2'd0, 32'h21212121);
        tick();
        drive_alu(5'd24, 32'h24242424);
        drive_ld(5'd22, 3'b010, 2'd0, 32'h22222222);
        tick();
        chk("pre_rst_ld_ready", 32'(ld_ready), 32'd0);
        idle_inputs();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("arst_rd_addr", 32'(rd_addr), 32'd0);
        chk("arst_wr_data", wr_data, 32'd0);
        chk("arst_stall", 32'(stall_req), 32'd0);
        chk("arst_ld_ready", 32'(ld_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_wr_en", 32'(rf_wr_en), 32'd0);
            chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        end
        drive_alu(5'd31, 32'hA5A5A5A5);
        tick();
        chk("post_rst_alu", 32'(rf_wr_en), 32'd1);
        idle_inputs();
        repeat (2) tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
